dispatch_unit: RTL and testbench
================================

DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 NUM_RS, 2, number of reservation-station channels, 1..4.
REQ-002 SLOT_W, 2, slot-index width per channel; tag width TAG_W = 2+SLOT_W, tag = {channel[1:0], slot}.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ib_empty  in  1  instruction buffer empty; ib_data_out holds the head when low.
REQ-006 ib_data_out  in  16  head instruction: op[15:12] ra[11:8] rb[7:4] rt[3:0]; imm8=[11:4], imm12=[11:0].
REQ-007 ib_pop  out  1  combinational; consumes the head at this edge.
REQ-008 ib_flush  out  1  registered one-cycle buffer-discard pulse.
REQ-009 branch_taken / branch_target  out  1 / 16  registered fetch-redirect pulse and address.
REQ-010 rs_ready / rs_slot  in  NUM_RS / NUM_RS*SLOT_W  per-channel free-slot flag and free-slot index.
REQ-011 rs_issue  out  NUM_RS  combinational one-hot issue strobe.
REQ-012 rs_op 2, rs_tag TAG_W, rs_a_rdy/rs_b_rdy 1, rs_a_val/rs_b_val 16, rs_a_tag/rs_b_tag TAG_W  out  shared issue payload.
REQ-013 cdb_valid 1, cdb_tag TAG_W, cdb_data 16  in  common data bus broadcast.
REQ-014 dbg_sel 4 in, dbg_reg 32 out: combinational {busy, src (15b, zero-extended tag), val} of selected register; halted 1 out.

Function
REQ-015 Block SHALL own 16 registers, each busy(1), src tag, val(16).
REQ-016 States: ISSUE, REDIRECT, HALT; pops occur only in ISSUE.
REQ-017 ALU op (op 0x0-0x3): channel c = op mod NUM_RS; pop and rs_issue[c] SHALL assert together iff !ib_empty and rs_ready[c]; else stall, no pop.
REQ-018 On issue: rs_op=op[1:0], rs_tag={c,rs_slot[c]}; per operand, not busy -> rdy=1, val=register val; busy -> rdy=0, tag=src.
REQ-019 On issue, rt SHALL become busy with src=rs_tag at the edge.
REQ-020 MOV (0x5): pop; rt <= {busy=0, val=zero-extended imm8} at edge; no rs_issue.
REQ-021 JMP (0x4): pop; at edge branch_taken<=1, branch_target<=zero-extended imm12, ib_flush<=1, state<=REDIRECT; both pulses last exactly one cycle.
REQ-022 REDIRECT: no pop, pulses deassert next edge, return to ISSUE; thus one JMP costs two cycles.
REQ-023 HLT (0xF): pop, state<=HALT, halted=1; HALT persists until reset.
REQ-024 Other opcodes: popped and discarded, no state change.
REQ-025 CDB: when cdb_valid, every register with busy && src==cdb_tag SHALL clear busy and load cdb_data, in all states.
REQ-026 Same edge CDB match and new issue to same rt: issue wins (busy=1, new tag).
REQ-027 Operand busy with src==cdb_tag while cdb_valid: behaviour per REQ-031/032.
REQ-028 rs_issue, ib_pop SHALL be 0 whenever reset is high.

Reset
REQ-029 On reset: state ISSUE; all registers busy=0, src=0, val=0; branch_taken=0, branch_target=0, ib_flush=0, halted=0; reset mid-REDIRECT or in HALT SHALL abort it.

Configuration
REQ-030 Macro DISPATCH_CDB_BYPASS_EN selects operand forwarding.
REQ-031 Defined: matching operand SHALL issue rdy=1, val=cdb_data that same cycle.
REQ-032 Undefined: instruction with a matching operand SHALL stall one cycle (no pop), then issue with register value.

Verification
REQ-033 Reset; MOV r1,0x12; MOV r2,0x34; ADD (0x0) r3=r1+r2, NUM_RS=2 -> rs_issue=01, a_val=0x0012, b_val=0x0034, rdy=1/1, r3 busy with tag {0,rs_slot[0]}.
REQ-034 ADD r3 (tag 0x1), then 0x1 op using r3, no CDB -> second issue on channel 1, a_rdy=0, a_tag=0x1; later cdb_valid tag 0x1 data 0xBEEF -> dbg_reg(3)={0,0,0xBEEF}.
REQ-035 JMP 0x020 at head -> next cycle branch_taken=1, branch_target=0x0020, ib_flush=1 for one cycle; no pop that cycle; pops resume cycle after.
REQ-036 rs_ready[0]=0 with ADD at head for 3 cycles -> ib_pop=0, rs_issue=0 for 3 cycles; issue in cycle rs_ready rises.
REQ-037 Operand tag equals concurrent CDB tag -> with DISPATCH_CDB_BYPASS_EN issue same cycle rdy=1 val=cdb_data; without, one stall cycle then rdy=1 val=cdb_data.
REQ-038 HLT then pending ADD -> halted=1, ib_pop=0 forever; assert reset in HALT -> halted=0, ADD issues after reset release.

Source files
------------

// File: rtl/dispatch_unit.sv
// -----------------------------------------------------------------------------
// dispatch_unit
//
// In-order dispatch stage. Pops instructions from the head of an instruction
// buffer, renames destination registers onto reservation-station tags, issues
// ALU operations to one of NUM_RS reservation-station channels, executes MOV /
// JMP / HLT locally and snoops the common data bus (CDB) to retire pending
// register results.
//
// Instruction format (16 bit):
//   op[15:12] ra[11:8] rb[7:4] rt[3:0]
//   imm8 = [11:4], imm12 = [11:0]
//
// Opcodes:
//   0x0-0x3 ALU op, channel = op mod NUM_RS, rs_op = op[1:0]
//   0x4     JMP imm12   (fetch redirect + buffer flush, two-cycle cost)
//   0x5     MOV rt,imm8
//   0xF     HLT         (sticky until reset)
//   others  popped and discarded
//
// Ports:
//   clk, reset                  sole clock, synchronous active-high reset
//   ib_empty, ib_data_out       instruction buffer head
//   ib_pop                      combinational pop of the head at this edge
//   ib_flush                    registered one-cycle buffer-discard pulse
//   branch_taken/branch_target  registered one-cycle fetch redirect
//   rs_ready/rs_slot            per-channel free-slot flag and index
//   rs_issue                    combinational one-hot issue strobe
//   rs_op, rs_tag, rs_{a,b}_*   shared issue payload
//   cdb_valid/cdb_tag/cdb_data  result broadcast
//   dbg_sel/dbg_reg             {busy, zero-extended src tag (15b), val}
//   halted                      high while in the HALT state
//
// Build option:
//   DISPATCH_CDB_BYPASS_EN  when defined, an operand whose producer is being
//                           broadcast on the CDB in the same cycle is
//                           forwarded directly into the issue payload. When
//                           undefined, such an instruction waits one cycle
//                           and then reads the freshly written register.
// -----------------------------------------------------------------------------
`default_nettype none

module dispatch_unit #(
    parameter int NUM_RS = 2,
    parameter int SLOT_W = 2,
    localparam int TAG_W = 2 + SLOT_W
) (
    input  logic                     clk,
    input  logic                     reset,

    // instruction buffer
    input  logic                     ib_empty,
    input  logic [15:0]              ib_data_out,
    output logic                     ib_pop,
    output logic                     ib_flush,

    // fetch redirect
    output logic                     branch_taken,
    output logic [15:0]              branch_target,

    // reservation stations
    input  logic [NUM_RS-1:0]        rs_ready,
    input  logic [NUM_RS*SLOT_W-1:0] rs_slot,
    output logic [NUM_RS-1:0]        rs_issue,
    output logic [1:0]               rs_op,
    output logic [TAG_W-1:0]         rs_tag,
    output logic                     rs_a_rdy,
    output logic                     rs_b_rdy,
    output logic [15:0]              rs_a_val,
    output logic [15:0]              rs_b_val,
    output logic [TAG_W-1:0]         rs_a_tag,
    output logic [TAG_W-1:0]         rs_b_tag,

    // common data bus
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [15:0]              cdb_data,

    // debug / status
    input  logic [3:0]               dbg_sel,
    output logic [31:0]              dbg_reg,
    output logic                     halted
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_ISSUE    = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [15:0]      busy_q, busy_d;
    logic [TAG_W-1:0] src_q [16];
    logic [TAG_W-1:0] src_d [16];
    logic [15:0]      val_q [16];
    logic [15:0]      val_d [16];

    logic             branch_taken_q, branch_taken_d;
    logic [15:0]      branch_target_q, branch_target_d;
    logic             ib_flush_q, ib_flush_d;
    logic             halted_q, halted_d;

    // -------------------------------------------------------------------------
    // Head decode
    // -------------------------------------------------------------------------
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rt;
    logic [7:0]  imm8;
    logic [11:0] imm12;

    assign op    = ib_data_out[15:12];
    assign ra    = ib_data_out[11:8];
    assign rb    = ib_data_out[7:4];
    assign rt    = ib_data_out[3:0];
    assign imm8  = ib_data_out[11:4];
    assign imm12 = ib_data_out[11:0];

    logic is_alu;
    assign is_alu = (op[3:2] == 2'b00);

    // Channel for an ALU op. With NUM_RS = 3 opcode 3 wraps onto channel 0.
    logic [1:0] chan;
    assign chan = 2'(32'(op[1:0]) % NUM_RS);

    // -------------------------------------------------------------------------
    // Channel select: one-hot decode, ready and free-slot mux
    // -------------------------------------------------------------------------
    logic [NUM_RS-1:0]        chan_oh;
    logic [NUM_RS*SLOT_W-1:0] slot_masked;

    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_chan
        assign chan_oh[gi] = (chan == 2'(gi));
        assign slot_masked[gi*SLOT_W +: SLOT_W] =
            chan_oh[gi] ? rs_slot[gi*SLOT_W +: SLOT_W] : '0;
    end

    logic [SLOT_W-1:0] sel_slot;
    always_comb begin
        sel_slot = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            sel_slot = sel_slot | slot_masked[i*SLOT_W +: SLOT_W];
        end
    end

    logic chan_ready;
    assign chan_ready = |(rs_ready & chan_oh);

    logic [TAG_W-1:0] issue_tag;
    assign issue_tag = {chan, sel_slot};

    // -------------------------------------------------------------------------
    // Source operand lookup and CDB snoop
    // -------------------------------------------------------------------------
    logic a_busy, b_busy;
    logic a_snoop, b_snoop;

    assign a_busy  = busy_q[ra];
    assign b_busy  = busy_q[rb];
    // The operand's producer is on the bus right now.
    assign a_snoop = a_busy && cdb_valid && (src_q[ra] == cdb_tag);
    assign b_snoop = b_busy && cdb_valid && (src_q[rb] == cdb_tag);

    logic operand_hold;

`ifdef DISPATCH_CDB_BYPASS_EN
    // Forward the broadcast value so the instruction issues without waiting.
    assign operand_hold = 1'b0;
    assign rs_a_rdy     = !a_busy || a_snoop;
    assign rs_b_rdy     = !b_busy || b_snoop;
    assign rs_a_val     = a_snoop ? cdb_data : val_q[ra];
    assign rs_b_val     = b_snoop ? cdb_data : val_q[rb];
`else
    // Without forwarding, issuing now would hand the station a tag that is
    // being broadcast this very cycle and would never be seen again. Hold
    // one cycle; the register file has the value by then.
    assign operand_hold = a_snoop || b_snoop;
    assign rs_a_rdy     = !a_busy;
    assign rs_b_rdy     = !b_busy;
    assign rs_a_val     = val_q[ra];
    assign rs_b_val     = val_q[rb];
`endif

    assign rs_a_tag = src_q[ra];
    assign rs_b_tag = src_q[rb];
    assign rs_op    = op[1:0];
    assign rs_tag   = issue_tag;

    // -------------------------------------------------------------------------
    // Pop / issue handshake
    // -------------------------------------------------------------------------
    logic can_pop;
    logic alu_go;
    logic issue_fire;
    logic mov_fire;
    logic jmp_fire;
    logic hlt_fire;

    // Reset gates the strobes directly so nothing leaves the block while the
    // state registers are being cleared.
    assign can_pop    = !reset && !ib_empty && (state_q == ST_ISSUE);
    assign alu_go     = chan_ready && !operand_hold;
    assign ib_pop     = can_pop && (!is_alu || alu_go);
    assign issue_fire = can_pop && is_alu && alu_go;
    assign rs_issue   = issue_fire ? chan_oh : '0;

    assign mov_fire = ib_pop && (op == OP_MOV);
    assign jmp_fire = ib_pop && (op == OP_JMP);
    assign hlt_fire = ib_pop && (op == OP_HLT);

    // -------------------------------------------------------------------------
    // Register file next state
    // -------------------------------------------------------------------------
    logic [15:0] cdb_hit;
    logic [15:0] rt_dec;

    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        assign cdb_hit[gi] = cdb_valid && busy_q[gi] && (src_q[gi] == cdb_tag);
        assign rt_dec[gi]  = (rt == 4'(gi));
    end

    // Priority within one edge: CDB writeback first, then the popped
    // instruction's own write to rt, so a new rename always wins over a
    // retiring older producer. The src field is cleared whenever a register
    // becomes ready, so it only carries meaning while busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < 16; i++) begin
            src_d[i] = src_q[i];
            val_d[i] = val_q[i];
            if (cdb_hit[i]) begin
                busy_d[i] = 1'b0;
                src_d[i]  = '0;
                val_d[i]  = cdb_data;
            end
            if (issue_fire && rt_dec[i]) begin
                busy_d[i] = 1'b1;
                src_d[i]  = issue_tag;
            end
            if (mov_fire && rt_dec[i]) begin
                busy_d[i] = 1'b0;
                src_d[i]  = '0;
                val_d[i]  = {8'h00, imm8};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and redirect pulses
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        branch_taken_d  = 1'b0;
        ib_flush_d      = 1'b0;
        branch_target_d = branch_target_q;
        case (state_q)
            ST_ISSUE: begin
                if (jmp_fire) begin
                    state_d         = ST_REDIRECT;
                    branch_taken_d  = 1'b1;
                    ib_flush_d      = 1'b1;
                    branch_target_d = {4'h0, imm12};
                end else if (hlt_fire) begin
                    state_d = ST_HALT;
                end
            end
            // One dead cycle while fetch refills; the pulses drop here.
            ST_REDIRECT: state_d = ST_ISSUE;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_ISSUE;
        endcase
    end

    assign halted_d = (state_d == ST_HALT);

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_ISSUE;
            busy_q          <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            ib_flush_q      <= 1'b0;
            halted_q        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                src_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            ib_flush_q      <= ib_flush_d;
            halted_q        <= halted_d;
            for (int i = 0; i < 16; i++) begin
                src_q[i] <= src_d[i];
                val_q[i] <= val_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign ib_flush      = ib_flush_q;
    assign halted        = halted_q;

    assign dbg_reg = {busy_q[dbg_sel], {(15-TAG_W){1'b0}}, src_q[dbg_sel], val_q[dbg_sel]};

endmodule

`default_nettype wire

// File: tb/tb_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_dispatch_unit
//
// Directed scenarios followed by a randomized run. Expected values come from
// a behavioural model of the architectural register file (busy/src/val per
// register) and of the dispatch rules; the DUT is never read back to form an
// expectation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dispatch_unit;

    localparam int NUM_RS = 2;
    localparam int SLOT_W = 2;
    localparam int TAG_W  = 2 + SLOT_W;

`ifdef DISPATCH_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     ib_empty;
    logic [15:0]              ib_data_out;
    logic                     ib_pop;
    logic                     ib_flush;
    logic                     branch_taken;
    logic [15:0]              branch_target;
    logic [NUM_RS-1:0]        rs_ready;
    logic [NUM_RS*SLOT_W-1:0] rs_slot;
    logic [NUM_RS-1:0]        rs_issue;
    logic [1:0]               rs_op;
    logic [TAG_W-1:0]         rs_tag;
    logic                     rs_a_rdy, rs_b_rdy;
    logic [15:0]              rs_a_val, rs_b_val;
    logic [TAG_W-1:0]         rs_a_tag, rs_b_tag;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [15:0]              cdb_data;
    logic [3:0]               dbg_sel;
    logic [31:0]              dbg_reg;
    logic                     halted;

    always #5 clk = ~clk;

    dispatch_unit #(.NUM_RS(NUM_RS), .SLOT_W(SLOT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ib_empty      (ib_empty),
        .ib_data_out   (ib_data_out),
        .ib_pop        (ib_pop),
        .ib_flush      (ib_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rs_ready      (rs_ready),
        .rs_slot       (rs_slot),
        .rs_issue      (rs_issue),
        .rs_op         (rs_op),
        .rs_tag        (rs_tag),
        .rs_a_rdy      (rs_a_rdy),
        .rs_b_rdy      (rs_b_rdy),
        .rs_a_val      (rs_a_val),
        .rs_b_val      (rs_b_val),
        .rs_a_tag      (rs_a_tag),
        .rs_b_tag      (rs_b_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .dbg_sel       (dbg_sel),
        .dbg_reg       (dbg_reg),
        .halted        (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic             m_busy [16];
    logic [TAG_W-1:0] m_src  [16];
    logic [15:0]      m_val  [16];
    bit               m_halt, m_redirect, m_bt, m_flush;
    logic [15:0]      m_target;

    // expectations for the current cycle
    logic              e_pop = 1'b0;
    logic [NUM_RS-1:0] e_issue = '0;
    logic [TAG_W-1:0]  e_tag;
    logic              e_a_rdy, e_b_rdy;
    logic [15:0]       e_a_val, e_b_val;
    logic [TAG_W-1:0]  e_a_tag, e_b_tag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_busy[i] = 1'b0;
            m_src[i]  = '0;
            m_val[i]  = '0;
        end
        m_halt = 0; m_redirect = 0; m_bt = 0; m_flush = 0;
        m_target = '0;
    endfunction

    task automatic drive(input logic emp, input logic [15:0] ins, input logic [NUM_RS-1:0] rdy,
                         input logic cv, input logic [TAG_W-1:0] ct, input logic [15:0] cd);
        ib_empty    = emp;
        ib_data_out = ins;
        rs_ready    = rdy;
        cdb_valid   = cv;
        cdb_tag     = ct;
        cdb_data    = cd;
    endtask

    // Predict this cycle's combinational and registered outputs and compare.
    task automatic eval_and_check();
        logic [3:0]        op, ra, rb;
        int                c;
        logic              a_snp, b_snp, stall;
        logic [SLOT_W-1:0] sl;
        logic [31:0]       exp_dbg;
        #1;
        op = ib_data_out[15:12];
        ra = ib_data_out[11:8];
        rb = ib_data_out[7:4];
        c  = int'(op[1:0]) % NUM_RS;
        sl = SLOT_W'(rs_slot >> (c * SLOT_W));
        e_tag = {2'(c), sl};
        a_snp = m_busy[ra] && cdb_valid && (m_src[ra] == cdb_tag);
        b_snp = m_busy[rb] && cdb_valid && (m_src[rb] == cdb_tag);
        stall = !BYP && (a_snp || b_snp);
        e_pop   = 1'b0;
        e_issue = '0;
        if (!reset && !m_halt && !m_redirect && !ib_empty) begin
            if (op < 4'h4) begin
                if (rs_ready[c] && !stall) begin
                    e_pop   = 1'b1;
                    e_issue = NUM_RS'(1) << c;
                end
            end else begin
                e_pop = 1'b1;
            end
        end
        e_a_rdy = !m_busy[ra] || (BYP && a_snp);
        e_b_rdy = !m_busy[rb] || (BYP && b_snp);
        e_a_val = (BYP && a_snp) ? cdb_data : m_val[ra];
        e_b_val = (BYP && b_snp) ? cdb_data : m_val[rb];
        e_a_tag = m_src[ra];
        e_b_tag = m_src[rb];

        check("ib_pop", 32'(ib_pop), 32'(e_pop));
        check("rs_issue", 32'(rs_issue), 32'(e_issue));
        if (e_issue != '0) begin
            check("rs_op", 32'(rs_op), 32'(op[1:0]));
            check("rs_tag", 32'(rs_tag), 32'(e_tag));
            check("rs_a_rdy", 32'(rs_a_rdy), 32'(e_a_rdy));
            check("rs_b_rdy", 32'(rs_b_rdy), 32'(e_b_rdy));
            if (e_a_rdy) check("rs_a_val", 32'(rs_a_val), 32'(e_a_val));
            else         check("rs_a_tag", 32'(rs_a_tag), 32'(e_a_tag));
            if (e_b_rdy) check("rs_b_val", 32'(rs_b_val), 32'(e_b_val));
            else         check("rs_b_tag", 32'(rs_b_tag), 32'(e_b_tag));
        end
        check("branch_taken", 32'(branch_taken), 32'(m_bt));
        check("ib_flush", 32'(ib_flush), 32'(m_flush));
        check("halted", 32'(halted), 32'(m_halt));
        if (m_bt) check("branch_target", 32'(branch_target), 32'(m_target));
        exp_dbg = {m_busy[dbg_sel], {(15-TAG_W){1'b0}}, m_src[dbg_sel], m_val[dbg_sel]};
        check("dbg_reg", dbg_reg, exp_dbg);
    endtask

    // Advance one clock and apply the architectural effects to the model.
    task automatic tick();
        logic [3:0] op, rt;
        @(posedge clk);
        op = ib_data_out[15:12];
        rt = ib_data_out[3:0];
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (cdb_valid && m_busy[i] && m_src[i] == cdb_tag) begin
                    m_busy[i] = 1'b0;
                    m_src[i]  = '0;
                    m_val[i]  = cdb_data;
                end
            end
            if (e_issue != '0) begin
                m_busy[rt] = 1'b1;
                m_src[rt]  = e_tag;
            end
            if (e_pop && op == 4'h5) begin
                m_busy[rt] = 1'b0;
                m_src[rt]  = '0;
                m_val[rt]  = {8'h00, ib_data_out[11:4]};
            end
            m_bt       = e_pop && (op == 4'h4);
            m_flush    = m_bt;
            m_redirect = m_bt;
            if (m_bt) m_target = {4'h0, ib_data_out[11:0]};
            if (e_pop && op == 4'hF) m_halt = 1;
        end
        #1;
    endtask

    task automatic cycle();
        eval_and_check();
        tick();
    endtask

    initial begin
        logic [3:0]  rop;
        logic [15:0] rins;
        logic [NUM_RS-1:0] rrdy;
        logic [TAG_W-1:0]  rtag;
        int r, j;

        model_reset();
        reset   = 1'b1;
        rs_slot = {2'd2, 2'd1};   // channel 1 slot 2, channel 0 slot 1
        dbg_sel = 4'd0;
        drive(1'b1, 16'h0000, 2'b11, 1'b0, '0, 16'h0);
        tick();
        tick();

        // reset state, strobes held low while reset is high
        drive(1'b0, 16'h0123, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("rst_branch_target", 32'(branch_target), 32'h0);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            check("rst_dbg_reg", dbg_reg, 32'h0);
        end
        tick();
        reset = 1'b0;

        // MOV r1,0x12 ; MOV r2,0x34 ; ADD r3=r1+r2
        drive(1'b0, 16'h5121, 2'b11, 1'b0, '0, 16'h0); cycle();
        drive(1'b0, 16'h5342, 2'b11, 1'b0, '0, 16'h0); cycle();
        drive(1'b0, 16'h0123, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("add_issue", 32'(rs_issue), 32'h1);
        check("add_a_val", 32'(rs_a_val), 32'h12);
        check("add_b_val", 32'(rs_b_val), 32'h34);
        check("add_rdy", 32'({rs_a_rdy, rs_b_rdy}), 32'h3);
        tick();
        dbg_sel = 4'd3;
        #1;
        check("add_r3_busy", dbg_reg, 32'h8001_0000);

        // op 0x1 reading r3 (tag 0x1), writing r4 on channel 1
        drive(1'b0, 16'h1324, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("dep_issue", 32'(rs_issue), 32'h2);
        check("dep_a_rdy", 32'(rs_a_rdy), 32'h0);
        check("dep_a_tag", 32'(rs_a_tag), 32'h1);
        tick();
        drive(1'b1, 16'h0000, 2'b11, 1'b0, '0, 16'h0); cycle(); cycle();
        drive(1'b1, 16'h0000, 2'b11, 1'b1, 4'h1, 16'hBEEF); cycle();
        drive(1'b1, 16'h0000, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("cdb_r3", dbg_reg, 32'h0000_BEEF);
        tick();

        // JMP 0x020
        drive(1'b0, 16'h4020, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("jmp_pop", 32'(ib_pop), 32'h1);
        tick();
        drive(1'b0, 16'h5AB9, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("jmp_taken", 32'(branch_taken), 32'h1);
        check("jmp_target", 32'(branch_target), 32'h0020);
        check("jmp_flush", 32'(ib_flush), 32'h1);
        check("jmp_no_pop", 32'(ib_pop), 32'h0);
        tick();
        eval_and_check();
        check("jmp_pulse_end", 32'({branch_taken, ib_flush}), 32'h0);
        check("jmp_pop_resume", 32'(ib_pop), 32'h1);
        tick();

        // channel 0 not ready for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0567, 2'b10, 1'b0, '0, 16'h0);
            eval_and_check();
            check("stall_pop", 32'(ib_pop), 32'h0);
            check("stall_issue", 32'(rs_issue), 32'h0);
            tick();
        end
        drive(1'b0, 16'h0567, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("stall_release", 32'(rs_issue), 32'h1);
        tick();

        // operand r4 (tag 0x6) produced on the CDB in the same cycle
        drive(1'b0, 16'h0418, 2'b11, 1'b1, 4'h6, 16'h1234);
        eval_and_check();
`ifdef DISPATCH_CDB_BYPASS_EN
        check("byp_issue", 32'(rs_issue), 32'h1);
        check("byp_a_rdy", 32'(rs_a_rdy), 32'h1);
        check("byp_a_val", 32'(rs_a_val), 32'h1234);
        tick();
`else
        check("hold_pop", 32'(ib_pop), 32'h0);
        check("hold_issue", 32'(rs_issue), 32'h0);
        tick();
        drive(1'b0, 16'h0418, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("hold_issue2", 32'(rs_issue), 32'h1);
        check("hold_a_rdy", 32'(rs_a_rdy), 32'h1);
        check("hold_a_val", 32'(rs_a_val), 32'h1234);
        tick();
`endif

        // HLT, then an ADD that must wait for reset
        drive(1'b0, 16'hF000, 2'b11, 1'b0, '0, 16'h0);
        eval_and_check();
        check("hlt_pop", 32'(ib_pop), 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0ABC, 2'b11, 1'b0, '0, 16'h0);
            eval_and_check();
            check("halt_flag", 32'(halted), 32'h1);
            check("halt_no_pop", 32'(ib_pop), 32'h0);
            tick();
        end
        reset = 1'b1;
        eval_and_check();
        check("rst_in_halt_pop", 32'(ib_pop), 32'h0);
        tick();
        reset = 1'b0;
        eval_and_check();
        check("post_rst_halted", 32'(halted), 32'h0);
        check("post_rst_issue", 32'(rs_issue), 32'h1);
        tick();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      rop = 4'($urandom_range(0, 3));
            else if (r < 72) rop = 4'h5;
            else if (r < 78) rop = 4'h4;
            else if (r < 80) rop = 4'hF;
            else             rop = 4'($urandom_range(6, 14));
            rins = {rop, 12'($urandom)};
            for (int b = 0; b < NUM_RS; b++) rrdy[b] = ($urandom_range(0, 3) != 0);
            j = int'($urandom_range(0, 15));
            rtag = m_busy[j] ? m_src[j] : TAG_W'($urandom);
            drive(($urandom_range(0, 4) == 0), rins, rrdy, 1'($urandom_range(0, 1)),
                  rtag, 16'($urandom));
            rs_slot = (NUM_RS*SLOT_W)'($urandom);
            dbg_sel = 4'($urandom);
            reset   = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
